// File: rtl/cla_nibble_seq_if.sv
// cla_nibble_seq_if: request-side bundle between a requester (master) and the nibble-serial adder (slave)
interface cla_nibble_seq_if #(parameter int WIDTH = 16);
  logic             start;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  modport master(output start, op_sub, a, b, input busy, done, sum, cout, ovf);
  modport slave(input start, op_sub, a, b, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/cla_nibble_seq.sv
// cla_nibble_seq: WIDTH-bit add/sub by stepping one shared 4-bit CLA slice LSB nibble first
// Ports: clk, rst (async, active-high); req (start/op_sub/a/b in, busy/done/sum/cout/ovf out);
//        slice_x/slice_y/slice_c0 drive the external slice, slice_s/slice_c4 return from it.
module cla_nibble_seq #(
  parameter int WIDTH = 16,
  localparam int NIB = WIDTH / 4
) (
  input  logic                clk,
  input  logic                rst,
  cla_nibble_seq_if.slave     req,
  output logic [3:0]          slice_x,
  output logic [3:0]          slice_y,
  output logic                slice_c0,
  input  logic [3:0]          slice_s,
  input  logic                slice_c4
);
  localparam int IW = NIB > 1 ? $clog2(NIB) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state, state_n;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_r, b_r, sum_r;
  logic             carry, cout_r, ovf_r;
  logic             accept, last;
  assign accept = req.start && state != RUN;
  assign last   = idx == IW'(NIB - 1);
  always_comb begin
    state_n  = accept ? RUN : state == RUN ? (last ? DONE : RUN) : IDLE;
    slice_x  = state == RUN ? a_r[{idx, 2'b00} +: 4] : 4'h0;
    slice_y  = state == RUN ? b_r[{idx, 2'b00} +: 4] : 4'h0;
    slice_c0 = state == RUN ? carry : 1'b0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      carry  <= 1'b0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        a_r   <= req.a;
        b_r   <= req.op_sub ? ~req.b : req.b;
        carry <= req.op_sub;
        idx   <= '0;
      end else if (state == RUN) begin
        sum_r[{idx, 2'b00} +: 4] <= slice_s;
        carry <= slice_c4;
        idx   <= idx + IW'(1);
        if (last) begin
          cout_r <= slice_c4;
          // slice_s[3] is the final sum MSB, landing this same edge
          ovf_r  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (slice_s[3] != a_r[WIDTH-1]);
        end
      end
    end
  end
  assign req.busy = state == RUN;
  assign req.done = state == DONE;
  assign req.sum  = sum_r;
  assign req.cout = cout_r;
  assign req.ovf  = ovf_r;
endmodule

// File: tb/tb_cla_nibble_seq.sv
// tb_cla_nibble_seq: directed scoreboard bench with a behavioural 4-bit slice
module tb_cla_nibble_seq;
  localparam int W = 16;
  localparam int N = W / 4;
  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] slice_x, slice_y, slice_s;
  logic       slice_c0, slice_c4;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  logic [W-1:0] ea, eb;
  logic         ec;
  cla_nibble_seq_if #(.WIDTH(W)) bus ();
  cla_nibble_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(bus.slave),
    .slice_x(slice_x), .slice_y(slice_y), .slice_c0(slice_c0),
    .slice_s(slice_s), .slice_c4(slice_c4)
  );
  assign {slice_c4, slice_s} = {1'b0, slice_x} + {1'b0, slice_y} + {4'h0, slice_c0};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic quiet(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_sx"}, 32'(slice_x), 0);
    chk({tag, "_sy"}, 32'(slice_y), 0);
    chk({tag, "_sc0"}, 32'(slice_c0), 0);
  endtask
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    logic [W:0] full;
    int r;
    exp_t e;
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.op_sub = sub;
    full = {1'b0, a} + {1'b0, sub ? ~b : b} + {{W{1'b0}}, sub};
    r = sub ? int'($signed(a)) - int'($signed(b)) : int'($signed(a)) + int'($signed(b));
    e.sum = full[W-1:0];
    e.cout = full[W];
    e.ovf = r > 32767 || r < -32768;
    q.push_back(e);
    ea = a; eb = sub ? ~b : b; ec = sub;
  endtask
  task automatic run(input bit poke, input int rst_at);
    int k;
    logic [4:0] t;
    exp_t e;
    k = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done || k > 20) break;
      chk("busy_run", 32'(bus.busy), 1);
      chk("slice_x", 32'(slice_x), 32'(ea[4*k +: 4]));
      chk("slice_y", 32'(slice_y), 32'(eb[4*k +: 4]));
      chk("slice_c0", 32'(slice_c0), 32'(ec));
      if (k == rst_at) begin
        #2 rst = 1'b1;
        #1;
        quiet("rst");
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_sum", 32'(bus.sum), 0);
        chk("rst_cout", 32'(bus.cout), 0);
        chk("rst_ovf", 32'(bus.ovf), 0);
        void'(q.pop_front());
        return;
      end
      t = {1'b0, ea[4*k +: 4]} + {1'b0, eb[4*k +: 4]} + {4'h0, ec};
      ec = t[4];
      if (poke && k == 1) begin
        bus.start = 1'b1; bus.a = '1; bus.b = '1; bus.op_sub = 1'b0;
      end
      k++;
    end
    chk("latency", 32'(k), N);
    quiet("done");
    e = q.pop_front();
    chk("sum", 32'(bus.sum), 32'(e.sum));
    chk("cout", 32'(bus.cout), 32'(e.cout));
    chk("ovf", 32'(bus.ovf), 32'(e.ovf));
  endtask
  task automatic idle_after();
    @(negedge clk);
    chk("done_pulse", 32'(bus.done), 0);
    quiet("idle");
  endtask
  initial begin
    bus.start = 1'b0; bus.op_sub = 1'b0; bus.a = '0; bus.b = '0;
    #2;
    chk("reset_done", 32'(bus.done), 0);
    chk("reset_sum", 32'(bus.sum), 0);
    quiet("reset");
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    drive(16'h1234, 16'h0FFF, 1'b0); run(1'b0, -1);
    chk("sum_2233", 32'(bus.sum), 32'h2233);
    idle_after();
    chk("sum_held", 32'(bus.sum), 32'h2233);
    @(negedge clk); drive(16'hFFFF, 16'h0001, 1'b0); run(1'b0, -1); idle_after();
    @(negedge clk); drive(16'h7FFF, 16'h0001, 1'b0); run(1'b0, -1);
    chk("ovf_7fff", 32'(bus.ovf), 1);
    idle_after();
    @(negedge clk); drive(16'h8000, 16'h0001, 1'b1); run(1'b0, -1);
    chk("sum_7fff", 32'(bus.sum), 32'h7FFF);
    idle_after();
    @(negedge clk); drive(16'h0003, 16'h0005, 1'b1); run(1'b0, -1); idle_after();
    @(negedge clk); drive(16'h1111, 16'h2222, 1'b0); run(1'b1, -1);
    chk("sum_3333", 32'(bus.sum), 32'h3333);
    drive(16'h0001, 16'h0001, 1'b0); run(1'b0, -1);
    chk("sum_0002", 32'(bus.sum), 32'h0002);
    idle_after();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(W'($urandom), W'($urandom), 1'($urandom));
      run(1'b0, -1);
    end
    idle_after();
    @(negedge clk); drive(16'hABCD, 16'h1234, 1'b0); run(1'b0, 2);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_done_after_rst", 32'(bus.done), 0);
    end
    drive(16'h4321, 16'h1234, 1'b1); run(1'b0, -1); idle_after();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
